// File: rtl/apb_wb_pkg.sv
// Shared types and helpers for the APB-to-Wishbone bridge.
package apb_wb_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    // Width of the per-transfer wait counter; wide enough for any TIMEOUT.
    localparam int CNT_W = 16;

    // Source lane feeding destination lane i when the lane order is reversed.
    function automatic int lane_reverse(input int i, input int lanes);
        return lanes - 1 - i;
    endfunction

endpackage

// File: rtl/byte_lane_swap.sv
// Reverses the order of LANES equal-width lanes. Used with 8-bit lanes for
// data and with 1-bit lanes for byte enables.
module byte_lane_swap
    import apb_wb_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int LANE_W = 8
) (
    input  logic [LANES*LANE_W-1:0] din,
    output logic [LANES*LANE_W-1:0] dout
);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam int SRC = lane_reverse(i, LANES);
        assign dout[i*LANE_W +: LANE_W] = din[SRC*LANE_W +: LANE_W];
    end

endmodule

// File: rtl/apb_wb_bridge.sv
// APB slave to pipelined Wishbone master bridge. One APB access becomes one
// single-beat Wishbone transfer; an address window optionally byte-reverses
// data and byte enables in both directions. A wait counter bounds every
// transfer and reports a slave error when it expires.
module apb_wb_bridge
    import apb_wb_pkg::*;
#(
    parameter int                ADDR_W     = 5,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] SWAP_MASK  = 5'b11000,
    parameter logic [ADDR_W-1:0] SWAP_MATCH = 5'b11000,
    parameter int                TIMEOUT    = 1023
) (
    input  logic                          clk,
    input  logic                          nreset,
    // APB slave
    input  logic [ADDR_W-1:0]             apb_PADDR,
    input  logic                          apb_PSEL,
    input  logic                          apb_PENABLE,
    input  logic                          apb_PWRITE,
    input  logic [DATA_W-1:0]             apb_PWDATA,
    input  logic [DATA_W/8-1:0]           apb_PSTRB,
    output logic                          apb_PREADY,
    output logic [DATA_W-1:0]             apb_PRDATA,
    output logic                          apb_PSLVERR,
    // Wishbone pipelined master
    output logic                          wb_cyc,
    output logic                          wb_stb,
    output logic                          wb_we,
    output logic [ADDR_W-$clog2(DATA_W/8)-1:0] wb_addr,
    output logic [DATA_W-1:0]             wb_data_o,
    output logic [DATA_W/8-1:0]           wb_sel,
    input  logic                          wb_stall,
    input  logic                          wb_ack,
    input  logic                          wb_err,
    input  logic [DATA_W-1:0]             wb_data_i
);

    localparam int                STRB_W = DATA_W / 8;
    localparam int                LSB    = $clog2(STRB_W);
    localparam logic [CNT_W-1:0]  TO_VAL = CNT_W'(TIMEOUT);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               swap_q;

    logic               swap_hit;
    logic [STRB_W-1:0]  sel_raw;
    logic [STRB_W-1:0]  sel_sw;
    logic [DATA_W-1:0]  wdata_sw;
    logic [DATA_W-1:0]  rdata_sw;
    logic [DATA_W-1:0]  rdata_fix;
    logic               resp;

    assign swap_hit  = (apb_PADDR & SWAP_MASK) == SWAP_MATCH;
    assign sel_raw   = apb_PWRITE ? apb_PSTRB : '1;
    assign rdata_fix = swap_q ? rdata_sw : wb_data_i;

    // A response counts only once the strobe has been accepted; ack and err
    // together resolve to an error further down.
    assign resp = ((state == S_REQ && !wb_stall) || state == S_WAIT) &&
                  (wb_ack || wb_err);

    byte_lane_swap #(.LANES(STRB_W), .LANE_W(8)) u_wdata_swap (
        .din  (apb_PWDATA),
        .dout (wdata_sw)
    );

    byte_lane_swap #(.LANES(STRB_W), .LANE_W(1)) u_sel_swap (
        .din  (sel_raw),
        .dout (sel_sw)
    );

    byte_lane_swap #(.LANES(STRB_W), .LANE_W(8)) u_rdata_swap (
        .din  (wb_data_i),
        .dout (rdata_sw)
    );

    // Transfer FSM with all bus outputs registered.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            swap_q      <= 1'b0;
            wb_cyc      <= 1'b0;
            wb_stb      <= 1'b0;
            wb_we       <= 1'b0;
            wb_addr     <= '0;
            wb_data_o   <= '0;
            wb_sel      <= '0;
            apb_PREADY  <= 1'b0;
            apb_PSLVERR <= 1'b0;
            apb_PRDATA  <= '0;
        end else begin
            apb_PREADY <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (apb_PSEL && apb_PENABLE) begin
                        wb_addr   <= apb_PADDR[ADDR_W-1:LSB];
                        wb_we     <= apb_PWRITE;
                        wb_data_o <= swap_hit ? wdata_sw : apb_PWDATA;
                        wb_sel    <= swap_hit ? sel_sw : sel_raw;
                        swap_q    <= swap_hit;
                        wb_cyc    <= 1'b1;
                        wb_stb    <= 1'b1;
                        cnt       <= '0;
                        state     <= S_REQ;
                    end
                end
                S_REQ, S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (state == S_REQ && !wb_stall)
                        wb_stb <= 1'b0;
                    if (resp) begin
                        wb_cyc      <= 1'b0;
                        wb_stb      <= 1'b0;
                        apb_PREADY  <= 1'b1;
                        apb_PSLVERR <= wb_err;
                        apb_PRDATA  <= wb_err ? '0 : rdata_fix;
                        state       <= S_DONE;
                    end else if (cnt == TO_VAL) begin
                        // Give up: the slave never answered in time.
                        wb_cyc      <= 1'b0;
                        wb_stb      <= 1'b0;
                        apb_PREADY  <= 1'b1;
                        apb_PSLVERR <= 1'b1;
                        apb_PRDATA  <= '0;
                        state       <= S_DONE;
                    end else if (state == S_REQ && !wb_stall) begin
                        state <= S_WAIT;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_wb_bridge.sv
// Directed bench for apb_wb_bridge: a 32-bit instance with a short timeout
// and a 64-bit instance with default settings.
module tb_apb_wb_bridge;

    logic clk;
    logic nreset;

    // 32-bit instance, TIMEOUT = 8
    logic [4:0]  a_paddr;
    logic        a_psel, a_penable, a_pwrite;
    logic [31:0] a_pwdata;
    logic [3:0]  a_pstrb;
    logic        a_pready, a_pslverr;
    logic [31:0] a_prdata;
    logic        a_cyc, a_stb, a_we;
    logic [2:0]  a_addr;
    logic [31:0] a_dato;
    logic [3:0]  a_sel;
    logic        a_stall, a_ack, a_err;
    logic [31:0] a_dati;

    // 64-bit instance, defaults otherwise
    logic [4:0]  b_paddr;
    logic        b_psel, b_penable, b_pwrite;
    logic [63:0] b_pwdata;
    logic [7:0]  b_pstrb;
    logic        b_pready, b_pslverr;
    logic [63:0] b_prdata;
    logic        b_cyc, b_stb, b_we;
    logic [1:0]  b_addr;
    logic [63:0] b_dato;
    logic [7:0]  b_sel;
    logic        b_stall, b_ack, b_err;
    logic [63:0] b_dati;

    int nvec = 0;
    int nerr = 0;

    apb_wb_bridge #(.ADDR_W(5), .DATA_W(32), .TIMEOUT(8)) dut_a (
        .clk(clk), .nreset(nreset),
        .apb_PADDR(a_paddr), .apb_PSEL(a_psel), .apb_PENABLE(a_penable),
        .apb_PWRITE(a_pwrite), .apb_PWDATA(a_pwdata), .apb_PSTRB(a_pstrb),
        .apb_PREADY(a_pready), .apb_PRDATA(a_prdata), .apb_PSLVERR(a_pslverr),
        .wb_cyc(a_cyc), .wb_stb(a_stb), .wb_we(a_we), .wb_addr(a_addr),
        .wb_data_o(a_dato), .wb_sel(a_sel), .wb_stall(a_stall),
        .wb_ack(a_ack), .wb_err(a_err), .wb_data_i(a_dati)
    );

    apb_wb_bridge #(.ADDR_W(5), .DATA_W(64)) dut_b (
        .clk(clk), .nreset(nreset),
        .apb_PADDR(b_paddr), .apb_PSEL(b_psel), .apb_PENABLE(b_penable),
        .apb_PWRITE(b_pwrite), .apb_PWDATA(b_pwdata), .apb_PSTRB(b_pstrb),
        .apb_PREADY(b_pready), .apb_PRDATA(b_prdata), .apb_PSLVERR(b_pslverr),
        .wb_cyc(b_cyc), .wb_stb(b_stb), .wb_we(b_we), .wb_addr(b_addr),
        .wb_data_o(b_dato), .wb_sel(b_sel), .wb_stall(b_stall),
        .wb_ack(b_ack), .wb_err(b_err), .wb_data_i(b_dati)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Setup phase then access phase; returns in the cycle after capture.
    task automatic a_access(input logic [4:0] ad, input logic w,
                            input logic [31:0] d, input logic [3:0] s);
        a_paddr = ad; a_pwrite = w; a_pwdata = d; a_pstrb = s;
        a_psel = 1'b1; a_penable = 1'b0;
        @(negedge clk);
        chk("a_setup_no_cyc", 64'(a_cyc), 64'h0);
        a_penable = 1'b1;
        @(negedge clk);
    endtask

    task automatic a_end();
        a_psel = 1'b0; a_penable = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nreset = 1'b0;
        a_paddr = '0; a_psel = 0; a_penable = 0; a_pwrite = 0; a_pwdata = '0; a_pstrb = '0;
        a_stall = 0; a_ack = 0; a_err = 0; a_dati = '0;
        b_paddr = '0; b_psel = 0; b_penable = 0; b_pwrite = 0; b_pwdata = '0; b_pstrb = '0;
        b_stall = 0; b_ack = 0; b_err = 0; b_dati = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_cyc",     64'(a_cyc),     64'h0);
        chk("rst_stb",     64'(a_stb),     64'h0);
        chk("rst_pready",  64'(a_pready),  64'h0);
        chk("rst_pslverr", 64'(a_pslverr), 64'h0);
        chk("rst_prdata",  64'(a_prdata),  64'h0);
        chk("rst_sel",     64'(a_sel),     64'h0);
        nreset = 1'b1;
        @(negedge clk);

        // Swapped write, zero-wait ack
        a_access(5'h18, 1'b1, 32'h11223344, 4'b0011);
        chk("sw_cyc",  64'(a_cyc),  64'h1);
        chk("sw_stb",  64'(a_stb),  64'h1);
        chk("sw_we",   64'(a_we),   64'h1);
        chk("sw_addr", 64'(a_addr), 64'h6);
        chk("sw_dato", 64'(a_dato), 64'h44332211);
        chk("sw_sel",  64'(a_sel),  64'hC);
        a_ack = 1'b1;
        a_paddr = 5'h00; a_pwdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("sw_pready",  64'(a_pready),  64'h1);
        chk("sw_pslverr", 64'(a_pslverr), 64'h0);
        chk("sw_cyc_off", 64'(a_cyc),     64'h0);
        chk("sw_dato_held", 64'(a_dato),  64'h44332211);
        a_ack = 1'b0; a_end();
        @(negedge clk);
        chk("sw_pready_once", 64'(a_pready), 64'h0);

        // Stall for three cycles
        a_stall = 1'b1;
        a_access(5'h04, 1'b0, 32'h0, 4'h0);
        chk("st_stb1", 64'(a_stb),  64'h1);
        chk("st_sel",  64'(a_sel),  64'hF);
        chk("st_we",   64'(a_we),   64'h0);
        chk("st_addr", 64'(a_addr), 64'h1);
        @(negedge clk);
        chk("st_stb2", 64'(a_stb), 64'h1);
        @(negedge clk);
        chk("st_stb3", 64'(a_stb), 64'h1);
        @(negedge clk);
        chk("st_stb4", 64'(a_stb), 64'h1);
        chk("st_nordy", 64'(a_pready), 64'h0);
        a_stall = 1'b0; a_ack = 1'b1; a_dati = 32'hCAFEF00D;
        @(negedge clk);
        chk("st_pready",  64'(a_pready),  64'h1);
        chk("st_stb_off", 64'(a_stb),     64'h0);
        chk("st_prdata",  64'(a_prdata),  64'hCAFEF00D);
        chk("st_pslverr", 64'(a_pslverr), 64'h0);
        a_ack = 1'b0; a_end();
        @(negedge clk);
        chk("st_pready_once", 64'(a_pready), 64'h0);
        chk("st_cyc_off",     64'(a_cyc),    64'h0);

        // Error on read, then a clean write that waits one cycle for ack
        a_access(5'h04, 1'b0, 32'h0, 4'h0);
        a_err = 1'b1; a_dati = 32'h12345678;
        @(negedge clk);
        chk("er_pready",  64'(a_pready),  64'h1);
        chk("er_pslverr", 64'(a_pslverr), 64'h1);
        chk("er_prdata",  64'(a_prdata),  64'h0);
        a_err = 1'b0; a_end();
        @(negedge clk);
        a_access(5'h00, 1'b1, 32'hA5A5A5A5, 4'b0110);
        chk("wr_dato", 64'(a_dato), 64'hA5A5A5A5);
        chk("wr_sel",  64'(a_sel),  64'h6);
        chk("wr_addr", 64'(a_addr), 64'h0);
        @(negedge clk);
        chk("wr_wait_cyc", 64'(a_cyc),     64'h1);
        chk("wr_wait_stb", 64'(a_stb),     64'h0);
        chk("wr_wait_rdy", 64'(a_pready),  64'h0);
        chk("er_held",     64'(a_pslverr), 64'h1);
        a_ack = 1'b1;
        @(negedge clk);
        chk("wr_pready",  64'(a_pready),  64'h1);
        chk("wr_pslverr", 64'(a_pslverr), 64'h0);
        a_ack = 1'b0; a_end();
        @(negedge clk);

        // Ack and err together resolve to error
        a_access(5'h08, 1'b0, 32'h0, 4'h0);
        a_ack = 1'b1; a_err = 1'b1; a_dati = 32'hFFFFFFFF;
        @(negedge clk);
        chk("ae_pready",  64'(a_pready),  64'h1);
        chk("ae_pslverr", 64'(a_pslverr), 64'h1);
        chk("ae_prdata",  64'(a_prdata),  64'h0);
        a_ack = 1'b0; a_err = 1'b0; a_end();
        @(negedge clk);

        // Timeout: strobe rises at s+0, PREADY at s+9, late ack at s+12
        a_access(5'h0C, 1'b0, 32'h0, 4'h0);
        repeat (8) @(negedge clk);
        chk("to_s8_rdy", 64'(a_pready), 64'h0);
        chk("to_s8_cyc", 64'(a_cyc),    64'h1);
        @(negedge clk);
        chk("to_pready",  64'(a_pready),  64'h1);
        chk("to_pslverr", 64'(a_pslverr), 64'h1);
        chk("to_prdata",  64'(a_prdata),  64'h0);
        chk("to_cyc",     64'(a_cyc),     64'h0);
        chk("to_stb",     64'(a_stb),     64'h0);
        a_end();
        repeat (3) @(negedge clk);
        a_ack = 1'b1; a_dati = 32'hBAD0BAD0;
        @(negedge clk);
        a_ack = 1'b0;
        chk("late_rdy",    64'(a_pready),  64'h0);
        chk("late_cyc",    64'(a_cyc),     64'h0);
        chk("late_prdata", 64'(a_prdata),  64'h0);
        chk("late_err",    64'(a_pslverr), 64'h1);
        a_dati = 32'h01020304;
        a_access(5'h18, 1'b0, 32'h0, 4'h0);
        a_ack = 1'b1;
        @(negedge clk);
        chk("rd_sw_pready",  64'(a_pready),  64'h1);
        chk("rd_sw_pslverr", 64'(a_pslverr), 64'h0);
        chk("rd_sw_prdata",  64'(a_prdata),  64'h04030201);
        a_ack = 1'b0; a_end();
        @(negedge clk);

        // Reset pulse while waiting for ack
        a_access(5'h10, 1'b0, 32'h0, 4'h0);
        @(negedge clk);
        chk("rw_wait_cyc", 64'(a_cyc), 64'h1);
        #2 nreset = 1'b0;
        #1;
        chk("rw_cyc",    64'(a_cyc),    64'h0);
        chk("rw_stb",    64'(a_stb),    64'h0);
        chk("rw_pready", 64'(a_pready), 64'h0);
        chk("rw_prdata", 64'(a_prdata), 64'h0);
        chk("rw_sel",    64'(a_sel),    64'h0);
        chk("rw_addr",   64'(a_addr),   64'h0);
        a_end();
        @(negedge clk);
        chk("rw_no_rdy", 64'(a_pready), 64'h0);
        nreset = 1'b1;
        @(negedge clk);
        chk("rw_idle_rdy", 64'(a_pready), 64'h0);
        a_access(5'h14, 1'b1, 32'h0BADCAFE, 4'hF);
        chk("rw_next_addr", 64'(a_addr), 64'h5);
        chk("rw_next_dato", 64'(a_dato), 64'h0BADCAFE);
        a_ack = 1'b1;
        @(negedge clk);
        chk("rw_next_pready",  64'(a_pready),  64'h1);
        chk("rw_next_pslverr", 64'(a_pslverr), 64'h0);
        a_ack = 1'b0; a_end();
        @(negedge clk);

        // 64-bit unswapped read at 0x08
        b_dati = 64'h0123456789ABCDEF;
        b_paddr = 5'h08; b_pwrite = 1'b0; b_psel = 1'b1;
        @(negedge clk);
        b_penable = 1'b1;
        @(negedge clk);
        chk("b_rd_addr", 64'(b_addr), 64'h1);
        chk("b_rd_sel",  64'(b_sel),  64'hFF);
        chk("b_rd_cyc",  64'(b_cyc),  64'h1);
        b_ack = 1'b1;
        @(negedge clk);
        chk("b_rd_pready",  64'(b_pready),  64'h1);
        chk("b_rd_prdata",  b_prdata,       64'h0123456789ABCDEF);
        chk("b_rd_pslverr", 64'(b_pslverr), 64'h0);
        b_ack = 1'b0; b_psel = 1'b0; b_penable = 1'b0;
        @(negedge clk);

        // 64-bit swapped write at 0x18
        b_paddr = 5'h18; b_pwrite = 1'b1; b_pwdata = 64'h0011223344556677;
        b_pstrb = 8'h0F; b_psel = 1'b1;
        @(negedge clk);
        b_penable = 1'b1;
        @(negedge clk);
        chk("b_wr_addr", 64'(b_addr), 64'h3);
        chk("b_wr_dato", b_dato,      64'h7766554433221100);
        chk("b_wr_sel",  64'(b_sel),  64'hF0);
        b_ack = 1'b1;
        @(negedge clk);
        chk("b_wr_pready", 64'(b_pready), 64'h1);
        b_ack = 1'b0; b_psel = 1'b0; b_penable = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
